// File: rtl/legv8_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : legv8_if_stage
//  Brief    : LEGv8 instruction fetch: PC, imem request, IF/ID register, HALT.
//  Revision : 1.0
// ============================================================================
module legv8_if_stage #(
    parameter int          ADDR_W    = 64,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [31:0]       if_id_inst,
    output logic              if_id_valid,
    output logic              halted,
    output logic              misalign
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   if_id_pc_q, if_id_pc_d;
    logic [31:0]         if_id_inst_q, if_id_inst_d;
    logic                if_id_valid_q, if_id_valid_d;
    logic                halted_q, halted_d;
    logic                misalign_q, misalign_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC[ADDR_W-1:0];
            if_id_pc_q    <= '0;
            if_id_inst_q  <= '0;
            if_id_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
            halted_q      <= halted_d;
            misalign_q    <= misalign_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        halted_d      = halted_q;
        misalign_d    = misalign_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, HALTED: begin
                if (br_taken) begin
                    // Redirect beats stall; a pending HALT is squashed by the older branch.
                    pc_d          = {br_target[ADDR_W-1:2], 2'b00};
                    misalign_d    = misalign_q | (|br_target[1:0]);
                    if_id_inst_d  = '0;
                    if_id_valid_d = 1'b0;
                    halted_d      = 1'b0;
                    state_d       = RUN;
                end else if (!stall) begin
                    if (state_q == RUN) begin
                        pc_d          = pc_q + ADDR_W'(4);
                        if_id_pc_d    = pc_q;
                        if_id_inst_d  = imem_rdata;
                        if_id_valid_d = 1'b1;
                        if (imem_rdata == HALT_INST) begin
                            state_d  = HALTED;
                            halted_d = 1'b1;
                        end
                    end else begin
                        if_id_inst_d  = '0;
                        if_id_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign imem_en     = (state_q == RUN) & ~stall;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_inst  = if_id_inst_q;
    assign if_id_valid = if_id_valid_q;
    assign halted      = halted_q;
    assign misalign    = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_legv8_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_legv8_if_stage
//  Brief    : Directed vector bench for legv8_if_stage.
//  Revision : 1.0
// ============================================================================
module tb_legv8_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = '0;
    logic [63:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        halted;
    logic        misalign;
    logic        halt_en = 1'b0;

    int errors = 0;
    int checks = 0;

    legv8_if_stage #(
        .ADDR_W   (64),
        .RESET_PC (64'h0),
        .HALT_INST(32'hFFFF_FFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_addr  (imem_addr),
        .imem_en    (imem_en),
        .imem_rdata (imem_rdata),
        .if_id_pc   (if_id_pc),
        .if_id_inst (if_id_inst),
        .if_id_valid(if_id_valid),
        .halted     (halted),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    // Memory word is A000_0000 | address, with an optional HALT at 0x10.
    function automatic logic [31:0] mem_word(input logic [63:0] a, input logic h);
        if (h && a == 64'h10) return 32'hFFFF_FFFF;
        return 32'hA000_0000 | a[31:0];
    endfunction

    assign imem_rdata = mem_word(imem_addr, halt_en);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic b, input logic [63:0] t);
        stall     = s;
        br_taken  = b;
        br_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [63:0] pc, input logic [63:0] ipc,
                             input logic [31:0] inst, input logic v, input logic h,
                             input logic m, input logic en);
        chk({tag, ".pc"},       imem_addr,   pc);
        chk({tag, ".if_pc"},    if_id_pc,    ipc);
        chk({tag, ".inst"},     {32'h0, if_id_inst}, {32'h0, inst});
        chk({tag, ".valid"},    {63'h0, if_id_valid}, {63'h0, v});
        chk({tag, ".halted"},   {63'h0, halted},   {63'h0, h});
        chk({tag, ".misalign"}, {63'h0, misalign}, {63'h0, m});
        chk({tag, ".imem_en"},  {63'h0, imem_en},  {63'h0, en});
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [63:0] tgt;
        logic [63:0] pc;
        logic [63:0] ipc;
        logic [31:0] inst;
        logic        v;
        logic        m;
        logic        en;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // Straight-line fetch, 2-cycle stall at PC=8, branch+stall to 0x40, misaligned branch.
        vecs[0]  = '{0, 0, 64'h0,  64'h0,  64'h0,  32'h0,         0, 0, 1};
        vecs[1]  = '{0, 0, 64'h0,  64'h4,  64'h0,  32'hA000_0000, 1, 0, 1};
        vecs[2]  = '{0, 0, 64'h0,  64'h8,  64'h4,  32'hA000_0004, 1, 0, 1};
        vecs[3]  = '{1, 0, 64'h0,  64'h8,  64'h4,  32'hA000_0004, 1, 0, 0};
        vecs[4]  = '{1, 0, 64'h0,  64'h8,  64'h4,  32'hA000_0004, 1, 0, 0};
        vecs[5]  = '{0, 0, 64'h0,  64'hC,  64'h8,  32'hA000_0008, 1, 0, 1};
        vecs[6]  = '{0, 0, 64'h0,  64'h10, 64'hC,  32'hA000_000C, 1, 0, 1};
        vecs[7]  = '{1, 1, 64'h40, 64'h40, 64'hC,  32'h0,         0, 0, 0};
        vecs[8]  = '{0, 0, 64'h0,  64'h44, 64'h40, 32'hA000_0040, 1, 0, 1};
        vecs[9]  = '{0, 0, 64'h0,  64'h48, 64'h44, 32'hA000_0044, 1, 0, 1};
        vecs[10] = '{0, 1, 64'h43, 64'h40, 64'h44, 32'h0,         0, 1, 1};
        vecs[11] = '{0, 0, 64'h0,  64'h44, 64'h40, 32'hA000_0040, 1, 1, 1};
        vecs[12] = '{0, 0, 64'h0,  64'h48, 64'h44, 32'hA000_0044, 1, 1, 1};

        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 64'h0, 64'h0, 32'h0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].stall, vecs[i].br, vecs[i].tgt);
            chk_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ipc, vecs[i].inst,
                      vecs[i].v, 1'b0, vecs[i].m, vecs[i].en);
        end

        // Asynchronous reset between edges clears outputs before any clock edge.
        stall = 1'b0; br_taken = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_state("async_rst", 64'h0, 64'h0, 32'h0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        halt_en = 1'b1;

        // HALT at 0x10.
        step(0, 0, 0);
        chk("boot.pc", imem_addr, 64'h0);
        chk("boot.valid", {63'h0, if_id_valid}, 64'h0);
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk_state("pre_halt", 64'h10, 64'hC, 32'hA000_000C, 1, 0, 0, 1);
        step(0, 0, 0);
        chk_state("halt_in", 64'h14, 64'h10, 32'hFFFF_FFFF, 1, 1, 0, 0);
        step(0, 0, 0);
        chk("halted1.pc",    imem_addr, 64'h14);
        chk("halted1.valid", {63'h0, if_id_valid}, 64'h0);
        chk("halted1.inst",  {32'h0, if_id_inst}, 64'h0);
        chk("halted1.flag",  {63'h0, halted}, 64'h1);
        step(0, 0, 0);
        chk("halted2.pc",    imem_addr, 64'h14);
        chk("halted2.valid", {63'h0, if_id_valid}, 64'h0);
        step(0, 1, 64'h0);
        chk("resume.pc",     imem_addr, 64'h0);
        chk("resume.halted", {63'h0, halted}, 64'h0);
        chk("resume.valid",  {63'h0, if_id_valid}, 64'h0);
        chk("resume.en",     {63'h0, imem_en}, 64'h1);
        step(0, 0, 0);
        chk_state("resume1", 64'h4, 64'h0, 32'hA000_0000, 1, 0, 0, 1);

        // PC wraps from 2^64-4 to 0.
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pre.pc", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0);
        chk_state("wrap", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
